procyon_sync_fifo_mp: RTL
=========================

Name: procyon_sync_fifo_mp

Overview:
- Multi-ported synchronous FIFO, successor to the single-entry FIFO.
- Accepts up to OPTN_PORTS entries per cycle and retires up to OPTN_PORTS entries per cycle, with first-word-fall-through reads.
- Provides occupancy and free-slot counts and a synchronous flush.
- Serves superscalar fetch/decode queues and miss queues where several entries move per cycle.

Parameters:
- OPTN_DATA_WIDTH, 8, width of one entry.
- OPTN_FIFO_DEPTH, 8, entries. Must be a power of 2 and >= 2*OPTN_PORTS.
- OPTN_PORTS, 2, max entries enqueued or dequeued per cycle. Must be >= 1.
- OPTN_AF_THRESH, 6, almost-full threshold; used only with the optional feature.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset. Asynchronous, active-low.
- i_flush  in  1  synchronous clear of all entries.
- i_enq_cnt  in  $clog2(OPTN_PORTS+1)  number of entries presented this cycle, taken from lanes 0..cnt-1.
- i_enq_data  in  OPTN_PORTS*OPTN_DATA_WIDTH  write lanes; lane 0 is oldest.
- o_enq_ready  out  1  combinational; i_enq_cnt <= free.
- i_deq_cnt  in  $clog2(OPTN_PORTS+1)  entries consumed this cycle.
- o_deq_data  out  OPTN_PORTS*OPTN_DATA_WIDTH  lane i = entry head+i.
- o_deq_valid  out  OPTN_PORTS  lane i valid iff i < count.
- o_fifo_count  out  $clog2(OPTN_FIFO_DEPTH)+1  registered occupancy.
- o_fifo_free  out  $clog2(OPTN_FIFO_DEPTH)+1  DEPTH - count.

Behaviour:
- Reset (async, n_rst low):
  - head=0, tail=0, count=0.
  - o_fifo_count=0, o_fifo_free=DEPTH, o_deq_valid=0, o_enq_ready=1 for any cnt <= PORTS.
  - Storage array is not reset; o_deq_data is don't-care while invalid.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Storage: flop array of DEPTH entries. head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue:
  - enq_acc = (i_enq_cnt <= free) ? i_enq_cnt : 0.
  - All-or-nothing: a partial group is never written.
  - Lane k is written to entry (tail+k) mod DEPTH at the clock edge.
  - tail advances by enq_acc.
- Dequeue:
  - deq_acc = min(i_deq_cnt, count). Over-request is clamped and is not an error.
  - head advances by deq_acc.
  - FWFT: o_deq_data lane i is a combinational read of entry (head+i) mod DEPTH. An entry written at edge N is visible on o_deq_data after edge N, i.e. one-cycle write-to-read latency.
- Simultaneous enqueue/dequeue:
  - Free space is judged on the registered count only. Slots freed this cycle are not reusable until the next cycle (no combinational deq->enq path).
  - count_next = count + enq_acc - deq_acc.
  - Computed at width $clog2(DEPTH)+1; never exceeds DEPTH, never underflows.
- Flush:
  - When i_flush is high at an edge: head=tail=count=0.
  - Flush has priority over that cycle's enqueue and dequeue; both are dropped.
- Wrap: multi-lane writes and reads straddling entry DEPTH-1 -> 0 wrap correctly.
- Full (count==DEPTH): o_enq_ready=0 for any nonzero cnt; i_enq_cnt==0 is always ready.
- Empty: o_deq_valid=0; dequeue requests are ignored.
- o_deq_valid is a thermometer decode of the registered count, saturating at OPTN_PORTS.

Optional Feature:
- Macro: PROCYON_SYNC_FIFO_AF_EN.
- Defined:
  - Adds port o_fifo_afull, out, 1.
  - Registered; equals (count_next >= OPTN_AF_THRESH), so it is coherent with o_fifo_count in the same cycle.
  - Reset value 0; forced to 0 by flush.
- Undefined: port and logic absent; OPTN_AF_THRESH unused.

Decomposition:
- Shared procyon_lib_pkg gets:
  - function procyon_fifo_idx_w(depth) returning $clog2(depth);
  - a parameter-check helper asserting power-of-2 depth.
- Top module keeps pointer/count state.
- One sub-module, procyon_sync_fifo_mp_rdmux: combinational rotate of the storage array to OPTN_PORTS output lanes indexed from head. Reusable for the write-lane scatter as well.

Test Plan (DW=8, DEPTH=8, PORTS=2):
- Reset then idle -> count=0, free=8, o_deq_valid=2'b00, o_enq_ready=1.
- Enqueue cnt=2 {0xA1,0xA2} then cnt=1 {0xA3} -> count=3. Lanes show 0xA1,0xA2 with valid=2'b11. Deq 2 -> lane0=0xA3, valid=2'b01, count=1.
- Fill to count=7, then enq cnt=2 -> o_enq_ready=0, nothing written, count stays 7. Enq cnt=1 -> count=8, free=0.
- Count=8, simultaneous deq 2 and enq 2 -> enqueue rejected, count=6. Next cycle enq 2 is accepted -> count=8. Data order preserved across wrap (tail 7->1).
- Count=1, i_deq_cnt=2 -> deq_acc=1, count=0, valid=0. Flush with enq cnt=2 pending -> count=0, no write. Async n_rst pulse mid-cycle -> outputs return to reset values before the next edge.
- With PROCYON_SYNC_FIFO_AF_EN, thresh 6: count 5->6 via enq 1 -> o_fifo_afull=1 the same cycle count shows 6. Deq 1 -> 0.

Source files
------------

// File: rtl/procyon_lib_pkg.sv
// Shared helpers for procyon queue structures: index widths and elaboration-time parameter checks.
package procyon_lib_pkg;

    function automatic int unsigned procyon_fifo_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit procyon_is_pow2(input int unsigned depth);
        return (depth != 0) && ((depth & (depth - 1)) == 0);
    endfunction

    // Legal multi-port FIFO geometry: power-of-2 depth holding at least two full port groups.
    function automatic bit procyon_fifo_params_ok(input int unsigned depth, input int unsigned ports);
        return procyon_is_pow2(depth) && (ports >= 1) && (depth >= 2 * ports);
    endfunction

endpackage

// File: rtl/procyon_sync_fifo_mp_rdmux.sv
// Rotates the flattened storage array so output lane i carries entry (base+i) mod DEPTH.
module procyon_sync_fifo_mp_rdmux
    import procyon_lib_pkg::*;
#(
    parameter  int unsigned OPTN_DATA_WIDTH = 8,
    parameter  int unsigned OPTN_FIFO_DEPTH = 8,
    parameter  int unsigned OPTN_PORTS      = 2,
    localparam int unsigned IDX_W           = procyon_fifo_idx_w(OPTN_FIFO_DEPTH)
) (
    input  logic [OPTN_FIFO_DEPTH*OPTN_DATA_WIDTH-1:0] i_mem,
    input  logic [IDX_W-1:0]                           i_base,
    output logic [OPTN_PORTS*OPTN_DATA_WIDTH-1:0]      o_lanes
);

    logic [IDX_W-1:0] idx;

    // Power-of-2 depth lets the pointer add wrap for free.
    always_comb begin
        idx     = '0;
        o_lanes = '0;
        for (int unsigned i = 0; i < OPTN_PORTS; i++) begin
            idx = i_base + IDX_W'(i);
            o_lanes[i*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH] = i_mem[idx*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
        end
    end

endmodule

// File: rtl/procyon_sync_fifo_mp.sv
// Multi-ported first-word-fall-through FIFO: up to OPTN_PORTS enqueues and dequeues per cycle.
// Define PROCYON_SYNC_FIFO_AF_EN to add the registered o_fifo_afull output.
module procyon_sync_fifo_mp
    import procyon_lib_pkg::*;
#(
    parameter int unsigned OPTN_DATA_WIDTH = 8,
    parameter int unsigned OPTN_FIFO_DEPTH = 8,
    parameter int unsigned OPTN_PORTS      = 2,
    parameter int unsigned OPTN_AF_THRESH  = 6
) (
    input  logic                                   clk,
    input  logic                                   n_rst,
    input  logic                                   i_flush,
    input  logic [$clog2(OPTN_PORTS+1)-1:0]        i_enq_cnt,
    input  logic [OPTN_PORTS*OPTN_DATA_WIDTH-1:0]  i_enq_data,
    output logic                                   o_enq_ready,
    input  logic [$clog2(OPTN_PORTS+1)-1:0]        i_deq_cnt,
    output logic [OPTN_PORTS*OPTN_DATA_WIDTH-1:0]  o_deq_data,
    output logic [OPTN_PORTS-1:0]                  o_deq_valid,
    output logic [$clog2(OPTN_FIFO_DEPTH):0]       o_fifo_count,
    output logic [$clog2(OPTN_FIFO_DEPTH):0]       o_fifo_free
`ifdef PROCYON_SYNC_FIFO_AF_EN
    ,
    output logic                                   o_fifo_afull
`endif
);

    localparam int unsigned IDX_W = procyon_fifo_idx_w(OPTN_FIFO_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned DW    = OPTN_DATA_WIDTH;

    if (!procyon_fifo_params_ok(OPTN_FIFO_DEPTH, OPTN_PORTS)) begin : g_bad_geometry
        $error("procyon_sync_fifo_mp: depth must be a power of 2 and >= 2*OPTN_PORTS");
    end
    if (OPTN_AF_THRESH > OPTN_FIFO_DEPTH) begin : g_bad_thresh
        $error("procyon_sync_fifo_mp: OPTN_AF_THRESH exceeds OPTN_FIFO_DEPTH");
    end

    logic [IDX_W-1:0]         head_q, head_d;
    logic [IDX_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [CNT_W-1:0]         free_q, free_d;
    logic [CNT_W-1:0]         enq_req, deq_req;
    logic [CNT_W-1:0]         enq_acc, deq_acc;
    logic [DW-1:0]            mem_q [OPTN_FIFO_DEPTH];
    logic [OPTN_FIFO_DEPTH*DW-1:0] mem_flat;

    // Admission uses the registered free count only; slots freed this cycle are reusable next cycle.
    always_comb begin
        enq_req = CNT_W'(i_enq_cnt);
        deq_req = CNT_W'(i_deq_cnt);
        enq_acc = (enq_req <= free_q) ? enq_req : '0;
        deq_acc = (deq_req < count_q) ? deq_req : count_q;
        head_d  = head_q + IDX_W'(deq_acc);
        tail_d  = tail_q + IDX_W'(enq_acc);
        count_d = count_q + enq_acc - deq_acc;
        free_d  = CNT_W'(OPTN_FIFO_DEPTH) - count_d;
        if (i_flush) begin
            enq_acc = '0;
            deq_acc = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            free_d  = CNT_W'(OPTN_FIFO_DEPTH);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= CNT_W'(OPTN_FIFO_DEPTH);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            free_q  <= free_d;
        end
    end

    // Storage is intentionally not reset; validity comes from count_q.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < OPTN_PORTS; k++) begin
            if (CNT_W'(k) < enq_acc) begin
                mem_q[tail_q + IDX_W'(k)] <= i_enq_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int unsigned j = 0; j < OPTN_FIFO_DEPTH; j++) begin
            mem_flat[j*DW +: DW] = mem_q[j];
        end
    end

    procyon_sync_fifo_mp_rdmux #(
        .OPTN_DATA_WIDTH (OPTN_DATA_WIDTH),
        .OPTN_FIFO_DEPTH (OPTN_FIFO_DEPTH),
        .OPTN_PORTS      (OPTN_PORTS)
    ) u_rdmux (
        .i_mem   (mem_flat),
        .i_base  (head_q),
        .o_lanes (o_deq_data)
    );

    always_comb begin
        o_deq_valid = '0;
        for (int unsigned i = 0; i < OPTN_PORTS; i++) begin
            o_deq_valid[i] = (count_q > CNT_W'(i));
        end
    end

    assign o_enq_ready  = (enq_req <= free_q);
    assign o_fifo_count = count_q;
    assign o_fifo_free  = free_q;

`ifdef PROCYON_SYNC_FIFO_AF_EN
    logic afull_q;

    // Tracks count_d so the flag changes in the same cycle as o_fifo_count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= i_flush ? 1'b0 : (count_d >= CNT_W'(OPTN_AF_THRESH));
        end
    end

    assign o_fifo_afull = afull_q;
`endif

endmodule
